// File: rtl/iic_slave_multi_interface.sv
// I2C slave byte engine answering NUM_CHANNELS consecutive addresses.
// Define IIC_SLAVE_CLK_STRETCH_EN to stall on not-ready writes and empty reads.
module iic_slave_multi_interface #(
    parameter logic [6:0] I2C_ADDRESS  = 7'h3c,
    parameter int         NUM_CHANNELS = 4,
    parameter int         FILTER_LEN   = 3,
    localparam int        LOG_N        = $clog2(NUM_CHANNELS),
    localparam int        CHAN_W       = (LOG_N < 1) ? 1 : LOG_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              scl_out_en,
    output logic              sda_out_en,
    output logic              wr_valid,
    output logic [7:0]        wr_data,
    output logic              wr_first,
    output logic [CHAN_W-1:0] wr_chan,
    input  logic              wr_ready,
    output logic              rd_req,
    output logic [CHAN_W-1:0] rd_chan,
    input  logic [7:0]        rd_data,
    input  logic              rd_empty,
    output logic              bus_busy,
    output logic              stop_pulse
);

`ifdef IIC_SLAVE_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    localparam logic [6:0] ADDR_MASK = 7'h7f << LOG_N;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK,
        RD_LOAD, RD_BYTE, RD_MACK, IGNORE
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]      s1_q, s2_q, f_q, f_d, p_q;
    logic [1:0][3:0] fcnt_q, fcnt_d;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d, wr_data_q, wr_data_d, ld;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic        rw_q, rw_d, arm_q, arm_d, empty_q, empty_d;
    logic        hold_q, hold_d, sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic        wr_valid_q, wr_valid_d, wr_first_q, wr_first_d;
    logic        rd_req_q, rd_req_d, busy_q, busy_d, stop_q, stop_d;
    logic        scl_rise, scl_fall, start_det, stop_det, byte_end;
    logic [6:0]  addr;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            f_d[i]    = f_q[i];
            fcnt_d[i] = 4'd0;
            if (s2_q[i] != f_q[i]) begin
                if (fcnt_q[i] >= 4'(FILTER_LEN - 1)) f_d[i] = s2_q[i];
                else fcnt_d[i] = fcnt_q[i] + 4'd1;
            end
        end
    end

    assign scl_rise  = f_q[0] & ~p_q[0];
    assign scl_fall  = ~f_q[0] & p_q[0];
    assign start_det = f_q[0] & p_q[0] & ~f_q[1] & p_q[1];
    assign stop_det  = f_q[0] & p_q[0] & f_q[1] & ~p_q[1];
    assign addr      = sh_q[7:1];
    assign byte_end  = scl_fall && (cnt_q == 4'd8);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        chan_d     = chan_q;
        rw_d       = rw_q;
        arm_d      = arm_q;
        empty_d    = empty_q;
        hold_d     = hold_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q;
        wr_data_d  = wr_data_q;
        wr_first_d = wr_first_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        stop_d     = 1'b0;
        ld         = empty_q ? 8'hff : rd_data;
        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            hold_d   = 1'b0;
            busy_d   = 1'b0;
            stop_d   = 1'b1;
        end else if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            hold_d   = 1'b0;
            busy_d   = 1'b1;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        sh_d  = {sh_q[6:0], f_q[1]};
                        cnt_d = cnt_q + 4'd1;
                    end else if (byte_end) begin
                        if (((addr ^ I2C_ADDRESS) & ADDR_MASK) == 7'd0
                            && addr != 7'd0) begin
                            chan_d   = CHAN_W'(addr & ~ADDR_MASK);
                            rw_d     = sh_q[0];
                            sda_oe_d = 1'b1;
                            state_d  = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    cnt_d    = 4'd0;
                    if (rw_q) begin
                        rd_req_d = 1'b1;
                        state_d  = RD_LOAD;
                    end else begin
                        arm_d   = 1'b1;
                        state_d = WR_BYTE;
                    end
                end
                WR_BYTE: begin
                    if ((hold_q || byte_end) && wr_ready) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = sh_q;
                        wr_first_d = arm_q;
                        arm_d      = 1'b0;
                        sda_oe_d   = 1'b1;
                        hold_d     = 1'b0;
                        state_d    = WR_ACK;
                    end else if (byte_end) begin
                        if (STRETCH) begin
                            scl_oe_d = 1'b1;
                            hold_d   = 1'b1;
                        end else begin
                            state_d = WR_ACK;
                        end
                    end else if (scl_rise && cnt_q != 4'd8) begin
                        sh_d  = {sh_q[6:0], f_q[1]};
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                WR_ACK: begin
                    scl_oe_d = 1'b0;
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = WR_BYTE;
                    end
                end
                // rd_req_q marks the request cycle; data arrives one cycle later
                RD_LOAD: begin
                    if (rd_req_q) begin
                        empty_d = rd_empty;
                        if (STRETCH && rd_empty) begin
                            scl_oe_d = 1'b1;
                            hold_d   = 1'b1;
                        end
                    end else if (hold_q) begin
                        if (!rd_empty) begin
                            rd_req_d = 1'b1;
                            hold_d   = 1'b0;
                        end
                    end else begin
                        sh_d     = ld;
                        sda_oe_d = ~ld[7];
                        scl_oe_d = 1'b0;
                        cnt_d    = 4'd1;
                        state_d  = RD_BYTE;
                    end
                end
                RD_BYTE: if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = RD_MACK;
                    end else begin
                        sda_oe_d = ~sh_q[6];
                        sh_d     = {sh_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 4'd1;
                    end
                end
                RD_MACK: begin
                    if (scl_rise && f_q[1]) begin
                        state_d = IGNORE;
                    end else if (scl_fall) begin
                        rd_req_d = 1'b1;
                        state_d  = RD_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 2'b11;
            s2_q       <= 2'b11;
            f_q        <= 2'b11;
            p_q        <= 2'b11;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 8'd0;
            chan_q     <= '0;
            rw_q       <= 1'b0;
            arm_q      <= 1'b0;
            empty_q    <= 1'b0;
            hold_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= 8'd0;
            wr_first_q <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            s1_q       <= {sda_in, scl_in};
            s2_q       <= s1_q;
            f_q        <= f_d;
            p_q        <= f_q;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            chan_q     <= chan_d;
            rw_q       <= rw_d;
            arm_q      <= arm_d;
            empty_q    <= empty_d;
            hold_q     <= hold_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_first_q <= wr_first_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_out_en = scl_oe_q;
    assign sda_out_en = sda_oe_q;
    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;
    assign wr_first   = wr_first_q;
    assign wr_chan    = chan_q;
    assign rd_req     = rd_req_q;
    assign rd_chan    = chan_q;
    assign bus_busy   = busy_q;
    assign stop_pulse = stop_q;

endmodule

// File: doc/iic_slave_multi_interface.md
Name: iic_slave_multi_interface

Overview:
- Parametrised next-generation I2C slave byte engine.
- Answers a block of NUM_CHANNELS consecutive 7-bit addresses and tags every byte with a channel index.
- Integrates SCL/SDA synchronisation, glitch filtering and START/STOP detection, so no external detector is needed.
- Sits between the open-drain pad cells and per-channel write/read FIFOs.

Parameters:
- I2C_ADDRESS, 7'h3c: base address. The low log2(NUM_CHANNELS) bits are ignored for matching.
- NUM_CHANNELS, 4: number of answered addresses, power of 2, 1..16.
- FILTER_LEN, 3: number of consecutive equal synchronised samples before a filtered line changes, 1..15.
- Localparam CHAN_W = max(1, clog2(NUM_CHANNELS)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scl_in  in  1  raw SCL pad input
- sda_in  in  1  raw SDA pad input
- scl_out_en  out  1  1 = pull SCL low (clock stretching)
- sda_out_en  out  1  1 = pull SDA low
- wr_valid  out  1  one-cycle pulse: received write byte
- wr_data  out  8  received byte
- wr_first  out  1  qualifies wr_valid: first byte after the address
- wr_chan  out  CHAN_W  channel of the write byte
- wr_ready  in  1  write sink can accept a byte
- rd_req  out  1  one-cycle pulse: request next read byte
- rd_chan  out  CHAN_W  channel of the read request
- rd_data  in  8  read byte, valid the cycle after rd_req
- rd_empty  in  1  no read data for rd_chan
- bus_busy  out  1  high between START and STOP
- stop_pulse  out  1  one-cycle pulse on STOP

Behaviour:
- Clock and reset: single clk domain. rst_n is asynchronous and active-low; all outputs and state clear immediately on assertion.
- Reset values: scl_out_en=0, sda_out_en=0, wr_valid=0, wr_data=0, wr_first=0, wr_chan=0, rd_req=0, rd_chan=0, bus_busy=0, stop_pulse=0. Filtered lines reset to 1. State = IDLE.
- Input path: 2-flop synchroniser, then the FILTER_LEN glitch filter. Edge detection operates on the filtered lines only.
- START: filtered SDA falls while SCL is high. STOP: filtered SDA rises while SCL is high.
- Bit timing: data bits are sampled on SCL rise. The slave changes SDA only on SCL fall. All bytes are MSB first.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_MACK, IGNORE.
- IDLE --START--> ADDR, with bit count = 0 and bus_busy=1.
- ADDR:
  - Shifts 8 bits.
  - On the SCL fall after bit 8: match if addr[6:log2N] == I2C_ADDRESS[6:log2N] and addr != 0.
  - On match: rd_chan and wr_chan take addr[log2N-1:0], sda_out_en=1, go to ADDR_ACK.
  - No match (including general call 0x00): go to IGNORE, SDA untouched.
- ADDR_ACK: on the next SCL fall, release SDA.
  - R/W=0: go to WR_BYTE and arm wr_first.
  - R/W=1: rd_req pulse, go to RD_LOAD.
- WR_BYTE: shifts 8 bits. On the SCL fall after bit 8:
  - If wr_ready=1: wr_valid pulse with wr_data, wr_first (then disarm), sda_out_en=1 (ACK), go to WR_ACK.
  - If wr_ready=0: no pulse, SDA released (NACK), go to WR_ACK.
- WR_ACK: on the next SCL fall, release SDA and return to WR_BYTE.
- RD_LOAD: one cycle after rd_req, latch rd_data into the shift register, or 8'hFF if rd_empty was high at rd_req. Drive bit 7 immediately (SCL is low).
- RD_BYTE:
  - Each later SCL fall drives the next bit; sda_out_en = ~bit.
  - On the fall after bit 8, release SDA and go to RD_MACK.
- RD_MACK: sample SDA on SCL rise.
  - 0 (ACK): on the next SCL fall, rd_req pulse and go to RD_LOAD.
  - 1 (NACK): go to IGNORE with SDA released.
- IGNORE: wait for START or STOP.
- STOP in any state: release SDA and SCL, stop_pulse, bus_busy=0, go to IDLE.
- Repeated START in any state: release SDA, reset bit count, go to ADDR. The next write byte has wr_first=1. An in-flight partial byte is discarded with no wr_valid.
- Simultaneous events: START/STOP detection has priority over bit processing in the same cycle.
- rd_req and wr_valid never assert in the same cycle.

Optional Feature:
- Macro: IIC_SLAVE_CLK_STRETCH_EN.
- Defined:
  - Write path: on the SCL fall after bit 8 with wr_ready=0, assert scl_out_en and hold. When wr_ready=1, pulse wr_valid, drive ACK, then release SCL one cycle later.
  - Read path: if rd_empty=1 at a read request, hold SCL low and re-issue rd_req every cycle rd_empty clears. Load the byte, then release SCL.
  - No 0xFF substitution and no NACK for not-ready.
- Undefined: scl_out_en is constant 0; not-ready writes are NACKed; empty reads return 8'hFF.

Test Plan:
- NUM_CHANNELS=4, write to address 0x3E with bytes 0xA5 and 0x5A: ACKs on the address and both bytes; wr_valid x2 with wr_chan=2, wr_first=1 then 0, wr_data 0xA5 then 0x5A; stop_pulse once.
- Address 0x40: no ACK, no wr_valid or rd_req, IGNORE until STOP; bus_busy drops on STOP.
- Read from 0x3D, rd_data=0xC3 then 0x81, master ACKs then NACKs: SDA bits 11000011, 10000001; two rd_req pulses with rd_chan=1; SDA released after the NACK.
- Write 0x3C with byte 0x11, repeated START, read 0x3C: the read sequence starts without stop_pulse; a following write gets wr_first=1; a partial byte aborted by the repeated START yields no wr_valid.
- Without IIC_SLAVE_CLK_STRETCH_EN, wr_ready=0: byte NACKed, no wr_valid. With the macro: SCL held low until wr_ready rises 20 cycles later, then wr_valid and ACK.
- 1-cycle glitches on SDA with FILTER_LEN=3 cause no false START/STOP. Asserting rst_n low mid-read releases SDA asynchronously with every output at its reset value.
